// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
package hazard_pkg;
  // Widest register address the scoreboard can hold; narrower AW is zero-extended.
  localparam int RD_W   = 8;
  localparam int CNT_W  = 32;
  // Forward select 0 means "read the register file".
  localparam int FWD_RF = 0;

  typedef struct packed {
    logic            valid;
    logic            we;
    logic [RD_W-1:0] rd;
    logic            is_load;
  } sb_entry_t;
endpackage

// File: rtl/hazard_scoreboard.sv
// In-flight destination tracker: one entry per post-decode stage, shifting
// toward WB every clock, with partial invalidation on a redirect.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int DEPTH  = 3,
  parameter int BR_IDX = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  sb_entry_t             ins,
  input  logic                  flush,
  output sb_entry_t [DEPTH-1:0] ent
);

  // Shift every clock; on flush, kill what lands in entries 1..BR_IDX
  // (everything younger than the redirecting instruction).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent <= '0;
    end else begin
      ent[0] <= ins;
      for (int i = 1; i < DEPTH; i++) begin
        if (flush && i <= BR_IDX) ent[i] <= '0;
        else                      ent[i] <= ent[i-1];
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller: RAW matching against the scoreboard,
// load-use stalls, redirect flushes and saturating event counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int AW       = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_IDX = 1,
  parameter int BR_IDX   = 1,
  parameter int FWD_EN   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       id_valid,
  input  logic [AW-1:0]              id_rs1,
  input  logic [AW-1:0]              id_rs2,
  input  logic                       id_use_rs1,
  input  logic                       id_use_rs2,
  input  logic [AW-1:0]              id_rd,
  input  logic                       id_we,
  input  logic                       id_is_load,
  input  logic                       redirect,
  output logic                       stall,
  output logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] fwd_rs1,
  output logic [$clog2(DEPTH+1)-1:0] fwd_rs2,
  output logic [CNT_W-1:0]           stall_cnt,
  output logic [CNT_W-1:0]           flush_cnt
);

  localparam int FW = $clog2(DEPTH+1);

  sb_entry_t [DEPTH-1:0] ent;
  sb_entry_t             ins;

  logic [1:0][AW-1:0] rs;
  logic [1:0]         use_rs;
  logic [1:0]         hit, hit_ld, haz;
  logic [1:0][FW-1:0] hit_idx, sel;

  assign rs     = {id_rs2, id_rs1};
  assign use_rs = {id_use_rs2, id_use_rs1};

  // Per source: scan oldest to youngest so the youngest producer overwrites,
  // then decide forward vs. stall from that producer's readiness.
  always_comb begin
    haz = '0;
    sel = {2{FW'(FWD_RF)}};
    for (int s = 0; s < 2; s++) begin
      hit[s]     = 1'b0;
      hit_ld[s]  = 1'b0;
      hit_idx[s] = '0;
      for (int i = DEPTH-1; i >= 0; i--) begin
        if (ent[i].valid && ent[i].we && ent[i].rd == RD_W'(rs[s])) begin
          hit[s]     = 1'b1;
          hit_ld[s]  = ent[i].is_load;
          hit_idx[s] = FW'(i);
        end
      end
      if (id_valid && use_rs[s] && rs[s] != '0 && hit[s]) begin
        if (FWD_EN == 0)                                     haz[s] = 1'b1;
        else if (hit_ld[s] && hit_idx[s] < FW'(LOAD_IDX))    haz[s] = 1'b1;
        else                                                 sel[s] = hit_idx[s] + FW'(1);
      end
    end
  end

  // Redirect wins over everything: flush, no stall, no forwarding.
  assign flush   = redirect;
  assign stall   = !redirect && (|haz);
  assign fwd_rs1 = redirect ? FW'(FWD_RF) : sel[0];
  assign fwd_rs2 = redirect ? FW'(FWD_RF) : sel[1];

  // New EX entry: decode fields, or a bubble when stalled/flushed/empty.
  always_comb begin
    ins = '0;
    if (id_valid && !stall && !flush) begin
      ins.valid   = 1'b1;
      ins.we      = id_we;
      ins.rd      = RD_W'(id_rd);
      ins.is_load = id_is_load;
    end
  end

  hazard_scoreboard #(
    .DEPTH  (DEPTH),
    .BR_IDX (BR_IDX)
  ) u_sb (
    .clk   (clk),
    .rst   (rst),
    .ins   (ins),
    .flush (flush),
    .ent   (ent)
  );

  // Saturating stall/flush cycle counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (forwarding on / off) fed the same
// decode stream; a history-of-issued-instructions model predicts outputs,
// a monitor compares them each cycle.
module tb_hazard_ctrl;
  localparam int DEPTH = 3, LOAD_IDX = 1, BR_IDX = 1, NC = 8192;
  localparam longint MAXC = 64'hFFFF_FFFF;

  logic clk = 1'b0, rst = 1'b1;
  logic id_valid = 0, id_use_rs1 = 0, id_use_rs2 = 0, id_we = 0, id_is_load = 0, redirect = 0;
  logic [4:0] id_rs1 = 0, id_rs2 = 0, id_rd = 0;
  logic [1:0] stall, flush;
  logic [1:0][1:0] fwd1, fwd2;
  logic [1:0][31:0] scnt, fcnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.AW(5), .DEPTH(DEPTH), .LOAD_IDX(LOAD_IDX), .BR_IDX(BR_IDX), .FWD_EN(1)) dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_we(id_we),
    .id_is_load(id_is_load), .redirect(redirect), .stall(stall[0]), .flush(flush[0]),
    .fwd_rs1(fwd1[0]), .fwd_rs2(fwd2[0]), .stall_cnt(scnt[0]), .flush_cnt(fcnt[0]));

  hazard_ctrl #(.AW(5), .DEPTH(DEPTH), .LOAD_IDX(LOAD_IDX), .BR_IDX(BR_IDX), .FWD_EN(0)) dut_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_we(id_we),
    .id_is_load(id_is_load), .redirect(redirect), .stall(stall[1]), .flush(flush[1]),
    .fwd_rs1(fwd1[1]), .fwd_rs2(fwd2[1]), .stall_cnt(scnt[1]), .flush_cnt(fcnt[1]));

  int n_chk = 0, n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: per config k (0 = forwarding, 1 = no forwarding), what
  // entered EX at each absolute cycle, and whether a redirect killed it.
  // The instruction issued at cycle c sits t-1-c stages past decode at cycle t.
  bit hv[2][NC], hwe[2][NC], hld[2][NC], hk[2][NC];
  int hrd[2][NC];
  int t = 0, base = 0;
  longint msc[2], mfc[2];
  bit last_st;

  typedef struct { bit st; bit fl; int f1; int f2; longint sc; longint fc; } exp_t;
  exp_t qa[$], qb[$];

  function automatic void scan(input int k, input int rs, input bit u, output bit haz, output int f);
    haz = 0; f = 0;
    if (!(id_valid && u && rs != 0)) return;
    for (int i = 0; i < DEPTH; i++) begin
      int c;
      c = t - 1 - i;
      if (c >= base && hv[k][c] && !hk[k][c] && hwe[k][c] && hrd[k][c] == rs) begin
        if (k == 1)                         haz = 1;
        else if (hld[k][c] && i < LOAD_IDX) haz = 1;
        else                                f = i + 1;
        return;
      end
    end
  endfunction

  task automatic do_cycle(input bit v, input int r1, input int r2, input bit u1, input bit u2,
                          input int rd, input bit we, input bit ld, input bit rdr);
    id_valid = v; id_rs1 = r1[4:0]; id_rs2 = r2[4:0]; id_use_rs1 = u1; id_use_rs2 = u2;
    id_rd = rd[4:0]; id_we = we; id_is_load = ld; redirect = rdr;
    for (int k = 0; k < 2; k++) begin
      bit h1, h2; int f1, f2; exp_t e;
      scan(k, r1, u1, h1, f1);
      scan(k, r2, u2, h2, f2);
      e.fl = rdr;
      e.st = !rdr && (h1 || h2);
      e.f1 = rdr ? 0 : f1;
      e.f2 = rdr ? 0 : f2;
      e.sc = msc[k];
      e.fc = mfc[k];
      if (k == 0) qa.push_back(e); else qb.push_back(e);
      hv[k][t] = v && !e.st && !rdr; hwe[k][t] = we; hrd[k][t] = rd; hld[k][t] = ld; hk[k][t] = 0;
      if (rdr) for (int i = 0; i < BR_IDX; i++) if (t - 1 - i >= 0) hk[k][t-1-i] = 1;
      if (e.st && msc[k] != MAXC) msc[k]++;
      if (rdr && mfc[k] != MAXC) mfc[k]++;
      if (k == 0) last_st = e.st;
    end
    t++;
  endtask

  task automatic cyc(input bit v, input int r1, input int r2, input bit u1, input bit u2,
                     input int rd, input bit we, input bit ld, input bit rdr);
    @(posedge clk); #1;
    do_cycle(v, r1, r2, u1, u2, rd, we, ld, rdr);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_stall"}, stall[k], 0);
      chk({tag, "_flush"}, flush[k], 0);
      chk({tag, "_fwd1"}, fwd1[k], 0);
      chk({tag, "_fwd2"}, fwd2[k], 0);
      chk({tag, "_scnt"}, scnt[k], 0);
      chk({tag, "_fcnt"}, fcnt[k], 0);
    end
  endtask

  // Release reset at posedge+1 and run one idle cycle in the same slot so no
  // unmodelled edge slips in.
  task automatic release_rst();
    @(posedge clk); #1;
    rst = 0; base = t; msc[0] = 0; msc[1] = 0; mfc[0] = 0; mfc[1] = 0;
    do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compare every cycle that has an expectation queued.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (qa.size() > 0) begin
        e = qa.pop_front();
        chk("a_stall", stall[0], e.st); chk("a_flush", flush[0], e.fl);
        chk("a_fwd1", fwd1[0], e.f1);   chk("a_fwd2", fwd2[0], e.f2);
        chk("a_scnt", scnt[0], e.sc);   chk("a_fcnt", fcnt[0], e.fc);
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        chk("b_stall", stall[1], e.st); chk("b_flush", flush[1], e.fl);
        chk("b_fwd1", fwd1[1], e.f1);   chk("b_fwd2", fwd2[1], e.f2);
        chk("b_scnt", scnt[1], e.sc);   chk("b_fcnt", fcnt[1], e.fc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit hold, v, u1, u2, we, ld, rdr;
    int r1, r2, rd;
    hold = 0; v = 0; u1 = 0; u2 = 0; we = 0; ld = 0; rdr = 0; r1 = 0; r2 = 0; rd = 0;
    msc[0] = 0; msc[1] = 0; mfc[0] = 0; mfc[1] = 0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk_all_zero("rst0");
    release_rst();

    // Load-use: lw x7 ; add x8,x7,x7 -> one stall, then forward from MEM.
    cyc(1, 1, 0, 1, 0, 7, 1, 1, 0);
    cyc(1, 7, 7, 1, 1, 8, 1, 0, 0); #1;
    chk("lu_stall", stall[0], 1); chk("lu_fwd_during", fwd1[0], 0);
    cyc(1, 7, 7, 1, 1, 8, 1, 0, 0); #1;
    chk("lu_release", stall[0], 0); chk("lu_fwd1", fwd1[0], 2); chk("lu_fwd2", fwd2[0], 2);
    chk("lu_scnt", scnt[0], 1);

    // ALU back-to-back and two apart.
    idle(4);
    cyc(1, 1, 2, 1, 1, 5, 1, 0, 0);
    cyc(1, 5, 3, 1, 1, 6, 1, 0, 0); #1;
    chk("alu_b2b_fwd", fwd1[0], 1); chk("alu_b2b_stall", stall[0], 0);
    idle(4);
    cyc(1, 1, 2, 1, 1, 5, 1, 0, 0);
    cyc(1, 10, 11, 1, 1, 12, 1, 0, 0);
    cyc(1, 5, 3, 1, 1, 6, 1, 0, 0); #1;
    chk("alu_gap_fwd", fwd1[0], 2);

    // No-forwarding instance: addi x4 ; add x9,x4,x0 stalls DEPTH cycles.
    idle(4);
    cyc(1, 0, 0, 1, 0, 4, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 4, 0, 1, 1, 9, 1, 0, 0); #1;
      chk("nofwd_stall", stall[1], (i < 3) ? 1 : 0);
    end
    chk("nofwd_fwd", fwd1[1], 0);

    // Double producer of x5: youngest wins; x0 never matches.
    idle(4);
    cyc(1, 1, 2, 1, 1, 5, 1, 0, 0);
    cyc(1, 1, 2, 1, 1, 7, 1, 0, 0);
    cyc(1, 1, 2, 1, 1, 5, 1, 0, 0);
    cyc(1, 5, 0, 1, 0, 3, 1, 0, 0); #1;
    chk("dbl_fwd", fwd1[0], 1);
    cyc(1, 0, 0, 1, 1, 0, 1, 1, 0);
    cyc(1, 0, 0, 1, 1, 3, 1, 0, 0); #1;
    chk("x0_stall_a", stall[0], 0); chk("x0_stall_b", stall[1], 0); chk("x0_fwd", fwd1[0], 0);

    // Redirect while a load-use stall is pending.
    idle(4);
    cyc(1, 1, 2, 1, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 1, 0, 7, 1, 1, 0);
    cyc(1, 7, 7, 1, 1, 8, 1, 0, 1); #1;
    chk("br_flush", flush[0], 1); chk("br_stall", stall[0], 0); chk("br_fwd", fwd1[0], 0);
    cyc(1, 7, 7, 1, 1, 8, 1, 0, 0); #1;
    chk("br_killed_stall", stall[0], 0); chk("br_killed_fwd", fwd1[0], 0);
    chk("br_fcnt", fcnt[0], 1); chk("br_scnt", scnt[0], 1);

    // Asynchronous reset in the middle of a load-use stall.
    idle(4);
    cyc(1, 1, 0, 1, 0, 7, 1, 1, 0);
    cyc(1, 7, 7, 1, 1, 8, 1, 0, 0); #1;
    chk("pre_rst_stall", stall[0], 1);
    @(negedge clk); #1;
    rst = 1; #1;
    chk_all_zero("rst_mid");
    release_rst();
    cyc(1, 7, 7, 1, 1, 8, 1, 0, 0); #1;
    chk("post_rst_stall", stall[0], 0); chk("post_rst_fwd", fwd1[0], 0);

    // Random traffic; decode holds its instruction while stalled.
    for (int n = 0; n < 1500; n++) begin
      if (!hold) begin
        v  = ($urandom_range(0, 9) != 0);
        r1 = $urandom_range(0, 7); r2 = $urandom_range(0, 7); rd = $urandom_range(0, 7);
        u1 = $urandom_range(0, 3) != 0; u2 = $urandom_range(0, 1);
        we = $urandom_range(0, 3) != 0; ld = ($urandom_range(0, 2) == 0);
      end
      rdr = ($urandom_range(0, 99) < 8);
      cyc(v, r1, r2, u1, u2, rd, we, ld, rdr);
      hold = last_st;
    end

    repeat (2) @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
